// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched
//   Frame scheduler for a WS2812 LED chain. Starts frames in the serial
//   transmitter, waits for their completion, enforces the low latch gap
//   after each frame and owns the bouncing animation step index
//   (0..STEP_MAX..1, repeating) used by the pixel data lookup.
//
//   Handshake with the transmitter: frame_start is a one-cycle request
//   pulse; the transmitter answers with a one-cycle frame_done pulse once
//   the last bit is sent. There is no back-pressure. A frame_done pulse
//   outside SEND is ignored.
//
//   Optional feature macro: FRAME_WDT_EN (frame-done watchdog, sticky
//   wdt_err). Without it, SEND waits indefinitely and wdt_err is 0.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   run          in   level: keep refreshing frames while high
//   frame_done   in   one-cycle pulse: transmitter finished the frame
//   frame_start  out  one-cycle pulse: start a frame
//   busy         out  high from frame_start to the end of the latch gap
//   step_idx     out  animation step, stable for a whole frame
//   wdt_err      out  sticky frame-done timeout flag
//   dbg_state    out  current FSM state (IDLE=0, START=1, SEND=2, LATCH=3)
module ws2812_frame_sched #(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned LATCH_US     = 300,
    parameter int unsigned STEP_MS      = 1000,
    parameter int unsigned STEP_MAX     = 3,
    parameter int unsigned WDT_CYCLES   = 2_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       run,
    input  logic       frame_done,
    output logic       frame_start,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       wdt_err,
    output logic [1:0] dbg_state
);

    localparam int unsigned LATCH_CYC = LATCH_US * CLK_FREQ_MHZ;
    localparam int unsigned US_W  = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int unsigned MS_W  = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam int unsigned LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam int unsigned PH_W  = (2 * STEP_MAX > 1) ? $clog2(2 * STEP_MAX) : 1;

    localparam logic [US_W-1:0]  US_LAST   = US_W'(CLK_FREQ_MHZ - 1);
    localparam logic [9:0]       MS_LAST   = 10'd999;
    localparam logic [MS_W-1:0]  STEP_LAST = MS_W'(STEP_MS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * STEP_MAX - 1);
    localparam logic [PH_W-1:0]  PH_TOP    = PH_W'(STEP_MAX);
    localparam logic [PH_W:0]    PH_SPAN   = (PH_W + 1)'(2 * STEP_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic [9:0]        ms_us_q, ms_us_d;
    logic [MS_W-1:0]   step_ms_q, step_ms_d;
    logic              step_pend_q, step_pend_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [3:0]        step_idx_q, step_idx_d;
    logic              frame_start_q;
    logic              busy_q;

    logic us_tick, ms_tick, step_tick, latch_end, go_start;
    logic wdt_hit;

`ifdef FRAME_WDT_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_err_q;

    // The counter reads 0 on the first SEND cycle, so a hit lands on the
    // WDT_CYCLES-th SEND cycle. A frame_done arriving on that same cycle
    // is a genuine completion and does not raise the error.
    assign wdt_hit   = (state_q == S_SEND) && !frame_done && (wdt_cnt_q == WDT_LAST);
    assign wdt_cnt_d = (state_q == S_SEND) ? wdt_cnt_q + 1'b1 : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_q | wdt_hit;
        end
    end

    assign wdt_err = wdt_err_q;
`else
    logic unused_wdt_cfg;

    assign wdt_hit        = 1'b0;
    assign unused_wdt_cfg = ^WDT_CYCLES;
    assign wdt_err        = 1'b0;
`endif

    always_comb begin
        // Free-running time base: us prescaler -> ms counter -> step period.
        us_tick   = (us_cnt_q == US_LAST);
        ms_tick   = us_tick && (ms_us_q == MS_LAST);
        step_tick = ms_tick && (step_ms_q == STEP_LAST);

        us_cnt_d  = us_tick ? '0 : us_cnt_q + 1'b1;
        ms_us_d   = ms_tick ? '0 : (us_tick ? ms_us_q + 1'b1 : ms_us_q);
        step_ms_d = step_tick ? '0 : (ms_tick ? step_ms_q + 1'b1 : step_ms_q);

        latch_end = (state_q == S_LATCH) && (lat_cnt_q == LAT_LAST);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (frame_done || wdt_hit) state_d = S_LATCH;
            S_LATCH: if (latch_end) state_d = run ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        go_start  = (state_d == S_START);
        lat_cnt_d = ((state_q == S_LATCH) && !latch_end) ? lat_cnt_q + 1'b1 : '0;

        // The step only moves on the way into START, so a frame never
        // mixes two steps. A tick landing on that same cycle stays pending
        // for the next frame; several ticks inside one frame collapse to one.
        ph_d = ph_q;
        if (go_start && step_pend_q) begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        end
        step_pend_d = step_tick | (step_pend_q & ~go_start);

        // Fold the phase into the bouncing index 0..STEP_MAX..1.
        step_idx_d = (ph_d <= PH_TOP) ? 4'(ph_d) : 4'(PH_SPAN - {1'b0, ph_d});
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            us_cnt_q      <= '0;
            ms_us_q       <= '0;
            step_ms_q     <= '0;
            step_pend_q   <= 1'b0;
            lat_cnt_q     <= '0;
            ph_q          <= '0;
            step_idx_q    <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            ms_us_q       <= ms_us_d;
            step_ms_q     <= step_ms_d;
            step_pend_q   <= step_pend_d;
            lat_cnt_q     <= lat_cnt_d;
            ph_q          <= ph_d;
            step_idx_q    <= step_idx_d;
            frame_start_q <= go_start;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign step_idx    = step_idx_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/ws2812_frame_sched.md
# ws2812_frame_sched

Frame scheduler for the WS2812 LED chain. It issues one-cycle frame-start requests to the serial LED transmitter and waits for frame completion. It then enforces the mandatory low latch gap before the next frame. It also owns the animation step index fed to the pixel data lookup: the index advances on a millisecond timer, bounces 0→STEP_MAX→0, and only changes between frames so a frame never mixes two steps.

## Interface
- CLK_FREQ_MHZ, 50, system clock frequency in MHz; sets the µs and ms prescalers.
- LATCH_US, 300, minimum low gap after each frame, in µs.
- STEP_MS, 1000, animation step period, in ms.
- STEP_MAX, 3, highest step index; index sequence is 0..STEP_MAX..1, repeating.
- WDT_CYCLES, 2_000_000, frame-done timeout in clock cycles; used only with FRAME_WDT_EN.

- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  level; 1 = keep refreshing frames, 0 = stop after the current frame and latch gap.
- frame_done  in  1  one-cycle pulse from the transmitter when the last bit of a frame is sent.
- frame_start  out  1  one-cycle pulse that starts a frame in the transmitter.
- busy  out  1  high from frame_start until the end of the latch gap.
- step_idx  out  4  animation step for data lookup; stable for a whole frame.
- wdt_err  out  1  sticky timeout flag; constant 0 when FRAME_WDT_EN is undefined.

## Operation
- FSM states are IDLE, START, SEND and LATCH. The reset state is IDLE.
- IDLE → START when run=1.
- START lasts exactly 1 cycle. frame_start=1 during START. Next state is SEND.
- SEND → LATCH on frame_done=1.
- LATCH counts LATCH_US×CLK_FREQ_MHZ cycles, starting at 0 on entry. On the terminal count:
  - go to START if run=1;
  - go to IDLE if run=0.
- busy is 1 in START, SEND and LATCH. busy is 0 in IDLE.
- run is sampled only in IDLE and at the end of LATCH. Deasserting run mid-frame never truncates the frame or the gap.
- A frame_done pulse seen in IDLE, START or LATCH is ignored.
- Step timer:
  - A free-running µs prescaler and a ms counter run whenever reset is deasserted, independent of FSM state.
  - Every STEP_MS ms, step_pend is set for 1.
- Step update:
  - Internal phase counter ph, range 0..2×STEP_MAX−1.
  - ph increments mod 2×STEP_MAX on the cycle the FSM leaves LATCH or IDLE for START while step_pend=1. step_pend clears on that same cycle.
  - step_idx = ph when ph ≤ STEP_MAX; otherwise 2×STEP_MAX−ph. step_idx is registered.
- Boundary conditions:
  - Multiple step periods elapsing during one frame advance ph only once.
  - A step_pend set and a transition to START in the same cycle: the pend is kept and applied at the next frame.
  - Reset mid-frame: all counters and the FSM return to reset values immediately. No frame_start is emitted until reset is released and run=1.

## Timing
- Reset values: frame_start=0, busy=0, step_idx=0, wdt_err=0. Internal state is ph=0, step_pend=0 and all counters 0.
- Latency from run rising in IDLE to frame_start: 1 cycle (registered).
- Latency from frame_done to busy falling: LATCH_US×CLK_FREQ_MHZ+1 cycles.
- Back-to-back frames with run held at 1: the next frame_start follows the last LATCH cycle with no idle cycle.
- step_idx changes on the same edge that asserts frame_start. It never changes while in SEND.

## Configuration
- The watchdog is controlled by the macro FRAME_WDT_EN.
- FRAME_WDT_EN defined:
  - A SEND-state counter runs and reaches its limit after WDT_CYCLES cycles without frame_done.
  - On reaching the limit, the FSM forces the transition to LATCH and sets wdt_err=1.
  - wdt_err stays 1 until reset.
- FRAME_WDT_EN undefined:
  - The watchdog counter is absent and wdt_err is tied to 0.
  - SEND waits indefinitely.

## Test plan
All scenarios use CLK_FREQ_MHZ=1, LATCH_US=10, STEP_MS=1, STEP_MAX=3, WDT_CYCLES=50.
- Raise run after reset, and return frame_done 20 cycles after each frame_start. Required: frame_start pulses exactly 31 cycles apart, and busy never drops.
- Hold run=1 for 8 ms. Required: the step_idx sequence at successive step changes is 0,1,2,3,2,1,0,1; step_idx is never seen changing while in SEND.
- Drop run during SEND. Required: SEND completes on frame_done, then 10 LATCH cycles, then IDLE with busy=0 and no further frame_start.
- Hold off frame_done for 3000 cycles, spanning three step periods. Required: ph advances by exactly 1 at the next frame_start.
- With FRAME_WDT_EN defined, never pulse frame_done. Required: on the 50th SEND cycle the FSM enters LATCH, wdt_err=1, and wdt_err stays 1 across subsequent frames. Without the macro, the FSM stays in SEND and wdt_err=0.
- Assert sys_rst_n=0 mid-SEND asynchronously. Required: outputs immediately read frame_start=0, busy=0, step_idx=0, wdt_err=0.
